// File: rtl/parallel_io_bank.sv
// parallel_io_bank: memory-mapped output/toggle registers plus a synchronised input port with change interrupt
module parallel_io_bank #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int N_OUT = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'hF0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_W-1:0]       Address,
  input  logic                    we,
  input  logic                    re,
  input  logic [DATA_W-1:0]       RegData,
  input  logic [DATA_W-1:0]       din,
  output logic                    wren,
  output logic                    hit,
  output logic [N_OUT*DATA_W-1:0] DataOut,
  output logic [DATA_W-1:0]       rdata,
  output logic                    rvalid,
  output logic                    irq
);
  logic [ADDR_W-1:0] off;
  logic [N_OUT-1:0][DATA_W-1:0] chan;
  logic [DATA_W-1:0] s1, din_s, din_prev, rsel;
  logic [1:0] arm_cnt;
  logic armed, chg, wr, rd, stat_wr;
  assign off = Address - BASE_ADDR;
  assign hit = (Address >= BASE_ADDR) && (off <= ADDR_W'(2 * N_OUT));
  assign wren = we & ~hit;
  assign wr = we & hit;
  assign rd = re & hit;
  assign stat_wr = wr && (off == ADDR_W'(2 * N_OUT));
  assign armed = &arm_cnt;
  assign chg = armed && (din_s != din_prev);
  assign DataOut = chan;
  always_comb begin
    rsel = din_s;
    for (int k = 0; k < N_OUT; k++)
      if (off == ADDR_W'(k) || off == ADDR_W'(k + N_OUT)) rsel = chan[k];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      chan <= '0;
      rdata <= '0;
      rvalid <= 1'b0;
      s1 <= '0;
      din_s <= '0;
      din_prev <= '0;
      arm_cnt <= '0;
      irq <= 1'b0;
    end else begin
      for (int k = 0; k < N_OUT; k++)
        if (wr && off == ADDR_W'(k)) chan[k] <= RegData;
        else if (wr && off == ADDR_W'(k + N_OUT)) chan[k] <= chan[k] ^ RegData;
      rvalid <= rd;
      if (rd) rdata <= rsel;
      {din_prev, din_s, s1} <= {din_s, s1, din};
      if (!armed) arm_cnt <= arm_cnt + 2'd1;
      irq <= chg | (irq & ~stat_wr);
    end
endmodule

// File: doc/parallel_io_bank.md
Name: parallel_io_bank

Overview:
- Memory-mapped parallel I/O bank on the CPU data bus. It decodes an address window and holds N_OUT writable output registers, each with a toggle alias. It also provides one synchronised, readable input port with change interrupt.
- Bus writes outside the window pass through to data memory as wren.
- Reads inside the window return registered data one cycle later.

Parameters:
- ADDR_W, 8, bus address width.
- DATA_W, 8, data width of every register and port.
- N_OUT, 4, number of output channels (1..8).
- BASE_ADDR, 8'hF0, first address of the window. Requires BASE_ADDR+2*N_OUT <= 2^ADDR_W-1.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Address  in  ADDR_W  bus address.
- we  in  1  bus write strobe.
- re  in  1  bus read strobe.
- RegData  in  DATA_W  bus write data.
- din  in  DATA_W  external asynchronous input pins.
- wren  out  1  memory write enable (combinational).
- hit  out  1  Address inside window (combinational).
- DataOut  out  N_OUT*DATA_W  output registers; channel k at bits [k*DATA_W +: DATA_W].
- rdata  out  DATA_W  registered read data.
- rvalid  out  1  rdata valid pulse.
- irq  out  1  input-change interrupt, level.

Behaviour:
- Address map, with off = Address-BASE_ADDR:
  - off 0..N_OUT-1 are OUT[k].
  - off N_OUT..2*N_OUT-1 are TGL[k].
  - off 2*N_OUT is STAT.
  - hit = 1 iff 0 <= off <= 2*N_OUT.
- wren = we & ~hit (pure combinational). Never asserted for window addresses.
- Write OUT[k] (we & hit): DataOut channel k <= RegData at the next edge.
- Write TGL[k]: channel k <= channel k XOR RegData (bitwise toggle).
- Write STAT: clears irq. RegData is ignored.
- Read (re & hit): at the next edge rdata <= selected value and rvalid <= 1. rvalid is 1 for exactly one cycle per accepted read.
  - OUT[k] or TGL[k] returns channel k.
  - STAT returns din_s.
- Read with re & ~hit: rvalid stays 0 and rdata holds its last value.
- Simultaneous we & re to the same address: rdata returns the pre-write value.
- Back-to-back reads give rvalid high on consecutive cycles with a fresh rdata each cycle.
- Input path: din passes through a 2-flop synchroniser to din_s, then to a prev register, giving latency 2 edges to din_s.
- Change detect: chg = armed & (din_s != din_prev).
- Arming: a 2-bit counter arm_cnt counts 0..3 after reset and saturates; armed = (arm_cnt == 3). This suppresses false interrupts while the synchroniser fills.
- irq: set when chg; cleared by STAT write; if chg and the STAT write occur in the same cycle, set wins. irq is a registered output.
- Reset (rst_n low, async, any time including mid-transaction):
  - DataOut, rdata, synchroniser, din_prev, arm_cnt all 0.
  - rvalid 0, irq 0.
  - A read pending at reset is discarded.
- Widths: no arithmetic beyond the offset compare, which is done at ADDR_W bits without wrap. Addresses below BASE_ADDR are not hits.

Test Plan:
- Reset then idle: rst_n=0 asynchronously mid-cycle -> DataOut=0, rdata=0, rvalid=0, irq=0 immediately; no irq within 10 cycles with din held at 8'h55.
- Out write/readback: we, Address=F2, RegData=8'hA5 -> channel 2 = A5, wren=0; then re at F2 -> next cycle rdata=A5, rvalid=1 for 1 cycle.
- Toggle: channel 1 = 8'h0F, write TGL[1] (F5) with 8'hFF -> channel 1 = F0; read F5 returns F0.
- Pass-through: we at Address=8'h10 and at 8'hF9 -> wren=1 both cycles, DataOut unchanged, rvalid never asserted on re to 8'h10.
- Input/irq: din 00->3C after arming -> din_s=3C after 2 edges, irq=1 on the following edge; read F8 returns 3C; write F8 clears irq; change coincident with STAT write -> irq stays 1.
- Same-cycle we & re on F0 (old 11, new 22) -> rdata=11, channel 0 = 22 after the edge.
